// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes and retire counter.
module multicycle_control_unit #(
   parameter int OP_W  = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  ir_opcode,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             branch_cond,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ExtOp,
   output logic             ALUSrc,
   output logic             MemRd,
   output logic             MemWrite,
   output logic             WBdata,
   output logic             illegal_op,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
   typedef enum logic [2:0] {CL_R, CL_ANDI, CL_ADDI, CL_LW, CL_SW, CL_BR, CL_J, CL_ILL} opClass_t;
   state_t curState, nextState;
   opClass_t opQ, decClass;
   logic retire;
   assign state = curState;
   // Full-width compares, so any bit above the 6-bit ISA range lands in CL_ILL.
   always_comb
      decClass = (ir_opcode <= OP_W'(2))  ? CL_R    :
                 (ir_opcode == OP_W'(3))  ? CL_ANDI :
                 (ir_opcode == OP_W'(4))  ? CL_ADDI :
                 (ir_opcode <= OP_W'(6))  ? CL_LW   :
                 (ir_opcode == OP_W'(7))  ? CL_SW   :
                 (ir_opcode <= OP_W'(11)) ? CL_BR   :
                 (ir_opcode <= OP_W'(13)) ? CL_J    : CL_ILL;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         curState    <= FETCH;
         opQ         <= CL_R;
         instr_count <= '0;
      end else begin
         curState <= nextState;
         if (curState == DECODE) opQ <= decClass;
         if (retire) instr_count <= instr_count + CNT_W'(1);
      end
   // Outputs are zero while rst_n is low, even in FETCH.
   always_comb begin
      nextState  = FETCH;
      retire     = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ExtOp      = 1'b0;
      ALUSrc     = 1'b0;
      MemRd      = 1'b0;
      MemWrite   = 1'b0;
      WBdata     = 1'b0;
      illegal_op = 1'b0;
      if (rst_n)
         case (curState)
            FETCH: begin
               imem_req  = 1'b1;
               ir_write  = imem_ready;
               pc_write  = imem_ready;
               nextState = imem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               illegal_op = decClass == CL_ILL;
               pc_write   = decClass == CL_J;
               pc_src     = (decClass == CL_J) ? 2'd2 : 2'd0;
               retire     = decClass == CL_J;
               nextState  = (decClass == CL_ILL || decClass == CL_J) ? FETCH : EXEC;
            end
            EXEC: begin
               ExtOp     = opQ inside {CL_ADDI, CL_LW, CL_SW, CL_BR};
               ALUSrc    = opQ inside {CL_ANDI, CL_ADDI, CL_LW, CL_SW};
               pc_write  = (opQ == CL_BR) && branch_cond;
               pc_src    = (opQ == CL_BR) ? 2'd1 : 2'd0;
               retire    = opQ == CL_BR;
               nextState = (opQ == CL_BR) ? FETCH : (opQ inside {CL_LW, CL_SW}) ? MEM : WB;
            end
            MEM: begin
               dmem_req  = 1'b1;
               ExtOp     = 1'b1;
               ALUSrc    = 1'b1;
               MemRd     = opQ == CL_LW;
               MemWrite  = opQ == CL_SW;
               retire    = dmem_ready && opQ == CL_SW;
               nextState = !dmem_ready ? MEM : (opQ == CL_LW) ? WB : FETCH;
            end
            WB: begin
               RegWrite = 1'b1;
               RegDst   = opQ == CL_R;
               WBdata   = opQ == CL_LW;
               retire   = 1'b1;
            end
            default: nextState = FETCH;
         endcase
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed-vector bench for the multi-cycle control unit.
module tb_multicycle_control_unit;
   logic clk = 1'b0, rst_n, rst2N, imemReady, dmemReady, branchCond;
   logic [5:0] opcode;
   logic [7:0] opcode2;
   logic imemReq, dmemReq, irWrite, pcWrite, regDst, regWrite, extOp, aluSrc, memRd, memWrite, wbData, illegalOp;
   logic [1:0] pcSrc;
   logic [2:0] st;
   logic [15:0] cnt;
   logic imemReq2, dmemReq2, irWrite2, pcWrite2, regDst2, regWrite2, extOp2, aluSrc2, memRd2, memWrite2, wbData2, illegalOp2;
   logic [1:0] pcSrc2;
   logic [2:0] st2;
   logic [3:0] cnt2;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .ir_opcode(opcode), .imem_ready(imemReady), .dmem_ready(dmemReady),
      .branch_cond(branchCond), .imem_req(imemReq), .dmem_req(dmemReq), .ir_write(irWrite),
      .pc_write(pcWrite), .pc_src(pcSrc), .RegDst(regDst), .RegWrite(regWrite), .ExtOp(extOp),
      .ALUSrc(aluSrc), .MemRd(memRd), .MemWrite(memWrite), .WBdata(wbData), .illegal_op(illegalOp),
      .state(st), .instr_count(cnt));

   multicycle_control_unit #(.OP_W(8), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst2N), .ir_opcode(opcode2), .imem_ready(imemReady), .dmem_ready(dmemReady),
      .branch_cond(branchCond), .imem_req(imemReq2), .dmem_req(dmemReq2), .ir_write(irWrite2),
      .pc_write(pcWrite2), .pc_src(pcSrc2), .RegDst(regDst2), .RegWrite(regWrite2), .ExtOp(extOp2),
      .ALUSrc(aluSrc2), .MemRd(memRd2), .MemWrite(memWrite2), .WBdata(wbData2), .illegal_op(illegalOp2),
      .state(st2), .instr_count(cnt2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0; rst2N = 1'b0; imemReady = 1'b1; dmemReady = 1'b1; branchCond = 1'b0;
      opcode = 6'd0; opcode2 = 8'd0;
      repeat (2) tick;
      check("rst_state", st, 0);
      check("rst_imem_req", imemReq, 0);
      check("rst_ir_write", irWrite, 0);
      check("rst_count", cnt, 0);
      rst_n = 1'b1; #1;
      check("rel_imem_req", imemReq, 1);
      check("rel_ir_write", irWrite, 1);
      // R-type: 0,1,2,4,0
      tick; check("r_dec", st, 1);
      tick; check("r_exec", st, 2);
      check("r_exec_alusrc", aluSrc, 0);
      check("r_exec_regwrite", regWrite, 0);
      tick; check("r_wb", st, 4);
      check("r_wb_regwrite", regWrite, 1);
      check("r_wb_regdst", regDst, 1);
      check("r_wb_pcwrite", pcWrite, 0);
      tick; check("r_fetch", st, 0);
      check("r_regwrite_off", regWrite, 0);
      check("r_count", cnt, 1);
      // LW with three stalled MEM cycles
      opcode = 6'd5; dmemReady = 1'b0;
      tick; check("lw_dec", st, 1);
      tick; check("lw_exec", st, 2);
      check("lw_exec_extop", extOp, 1);
      check("lw_exec_alusrc", aluSrc, 1);
      opcode = 6'd7;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("lw_mem_state", st, 3);
         check("lw_mem_rd", memRd, 1);
         check("lw_mem_req", dmemReq, 1);
         check("lw_mem_wr", memWrite, 0);
      end
      dmemReady = 1'b1; #1;
      check("lw_mem4_state", st, 3);
      check("lw_mem4_rd", memRd, 1);
      tick; check("lw_wb", st, 4);
      check("lw_wb_data", wbData, 1);
      check("lw_wb_regdst", regDst, 0);
      check("lw_wb_regwrite", regWrite, 1);
      tick; check("lw_fetch", st, 0);
      check("lw_count", cnt, 2);
      // Branch taken, then not taken
      opcode = 6'd8; branchCond = 1'b1;
      tick; tick;
      check("bt_exec", st, 2);
      check("bt_pcwrite", pcWrite, 1);
      check("bt_pcsrc", pcSrc, 1);
      check("bt_extop", extOp, 1);
      check("bt_alusrc", aluSrc, 0);
      check("bt_regwrite", regWrite, 0);
      tick; check("bt_fetch", st, 0);
      check("bt_count", cnt, 3);
      branchCond = 1'b0;
      tick; tick;
      check("bn_exec", st, 2);
      check("bn_pcwrite", pcWrite, 0);
      check("bn_pcsrc", pcSrc, 1);
      tick; check("bn_fetch", st, 0);
      check("bn_count", cnt, 4);
      // Illegal 6'h3F
      opcode = 6'h3F;
      tick; check("ill_dec", st, 1);
      check("ill_pulse", illegalOp, 1);
      check("ill_pcwrite", pcWrite, 0);
      check("ill_regwrite", regWrite, 0);
      tick; check("ill_fetch", st, 0);
      check("ill_pulse_off", illegalOp, 0);
      check("ill_count", cnt, 4);
      // Fetch stall, then J
      opcode = 6'd12; imemReady = 1'b0; #1;
      check("stall_req", imemReq, 1);
      check("stall_irw", irWrite, 0);
      check("stall_pcw", pcWrite, 0);
      tick; check("stall_state", st, 0);
      imemReady = 1'b1;
      tick; check("j_dec", st, 1);
      check("j_pcwrite", pcWrite, 1);
      check("j_pcsrc", pcSrc, 2);
      tick; check("j_fetch", st, 0);
      check("j_count", cnt, 5);
      // Reset during SW MEM
      opcode = 6'd7; dmemReady = 1'b0;
      tick; tick; tick;
      check("sw_mem", st, 3);
      check("sw_memwrite", memWrite, 1);
      check("sw_memrd", memRd, 0);
      rst_n = 1'b0; #1;
      check("sw_rst_memwrite", memWrite, 0);
      check("sw_rst_dmemreq", dmemReq, 0);
      check("sw_rst_state", st, 0);
      check("sw_rst_count", cnt, 0);
      #3; rst_n = 1'b1; #1;
      check("sw_rel_imemreq", imemReq, 1);
      // Wide opcode instance: 8'h40 is illegal, then 16 J wrap the 4-bit counter
      dmemReady = 1'b1;
      @(negedge clk);
      opcode2 = 8'h40; rst2N = 1'b1;
      tick; check("w_ill_dec", st2, 1);
      check("w_ill_pulse", illegalOp2, 1);
      check("w_ill_pcwrite", pcWrite2, 0);
      tick; check("w_ill_fetch", st2, 0);
      check("w_ill_count", cnt2, 0);
      opcode2 = 8'd12;
      for (int i = 1; i <= 16; i++) begin
         tick;
         check("w_j_pcsrc", pcSrc2, 2);
         check("w_j_pcwrite", pcWrite2, 1);
         tick;
         if (i == 15) check("w_count15", cnt2, 15);
      end
      check("w_count_wrap", cnt2, 0);
      check("w_state", st2, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
